scpad_tail: RTL and testbench
=============================

Name: scpad_tail

Overview:
- Response-side end of one scratchpad bank port; counterpart to the request head that arbitrates FE/BE requests into the SRAM pipeline.
- Records the source (FE or BE) of each granted request in issue order and steers read data and write acks back to the correct requester.
- Buffers read responses when the requester is not ready.
- Generates `r_stall`/`w_stall` credit back-pressure toward the head so in-flight work never exceeds buffer capacity.

Parameters:
- IDX, '0, scratchpad instance id (SCPAD_ID_WIDTH bits); used only for naming/selection in parent.
- RD_DEPTH, 4, max outstanding reads (issued, not yet delivered); power of two, >=2.
- WR_DEPTH, 4, max outstanding writes (issued, not yet acked); power of two, >=2.

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `rd_issue_valid`  in  1  head granted a read this cycle.
- `rd_issue_src`  in  1  source of that read: 1=BE, 0=FE.
- `wr_issue_valid`  in  1  head granted a write this cycle.
- `wr_issue_src`  in  1  source of that write: 1=BE, 0=FE.
- `body_rd_rsp_valid`  in  1  SRAM pipeline returns read data (in issue order).
- `body_rd_rsp`  in  rd_rsp_t  read response payload.
- `body_wr_ack_valid`  in  1  SRAM pipeline completed a write (in issue order).
- `be_rd_rsp_valid`  out  1  read response for BE.
- `be_rd_rsp`  out  rd_rsp_t  BE read payload.
- `be_rd_rsp_ready`  in  1  BE accepts response.
- `fe_rd_rsp_valid`  out  1  read response for FE.
- `fe_rd_rsp`  out  rd_rsp_t  FE read payload.
- `fe_rd_rsp_ready`  in  1  FE accepts response.
- `be_wr_ack`  out  1  one-cycle write-done pulse to BE.
- `fe_wr_ack`  out  1  one-cycle write-done pulse to FE.
- `r_stall`  out  1  read credits exhausted; head must not grant reads.
- `w_stall`  out  1  write credits exhausted; head must not grant writes.
- `err`  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0; FIFOs empty; credit counters 0; `err` 0. Mid-operation reset discards all in-flight state with no output pulses.
- Read source FIFO (RD_DEPTH x 1b):
  - Push `rd_issue_src` on `rd_issue_valid`.
  - Pop on `body_rd_rsp_valid`; the popped source tags the response.
- Read response buffer (RD_DEPTH entries of {src, rd_rsp_t}):
  - Push on `body_rd_rsp_valid`.
  - Head entry drives exactly one of `be_rd_rsp_valid`/`fe_rd_rsp_valid` (per src) combinationally from the registered FIFO head.
  - Pop when the selected valid and matching ready are both high.
  - Strict in-order delivery: a stalled BE head blocks a queued FE response.
- Read credits: `rd_cnt` increments on `rd_issue_valid` and decrements on response pop. Both in one cycle leaves it unchanged.
  - `r_stall = (rd_cnt == RD_DEPTH)`, driven from the register with no same-cycle lookahead.
  - Push with a full response buffer cannot occur while credits are honoured.
- Minimum latency: body response at cycle N gives requester valid at N+1.
- Write path:
  - Source FIFO (WR_DEPTH x 1b) pushes on `wr_issue_valid` and pops on `body_wr_ack_valid`.
  - Ack pulse is registered: `be_wr_ack` or `fe_wr_ack` is high for exactly cycle N+1. No ready; acks are never dropped.
  - `wr_cnt` increments on issue and decrements on ack. `w_stall = (wr_cnt == WR_DEPTH)`.
- Simultaneous events:
  - Issue and response in the same cycle, including with the FIFO empty (issue then response later), are both honoured.
  - Push and pop on a full buffer in the same cycle is legal. Pointers wrap modulo depth.
- `err` is set and held until reset on any of:
  - `body_rd_rsp_valid` with the read source FIFO empty;
  - `body_wr_ack_valid` with the write source FIFO empty;
  - `rd_issue_valid` while `r_stall`;
  - `wr_issue_valid` while `w_stall`.
  - The offending event is ignored: no push, pop, or count change.
- Counters are $clog2(DEPTH)+1 bits wide; they never wrap.

Decomposition:
- `rd_rsp_t` (read data vector plus metadata) belongs in scpad_types_pkg alongside the request types.
- Also in the package: the SCPAD_SRC_BE/SCPAD_SRC_FE constants and the default depth localparams.
- Natural sub-module: scpad_sync_fifo #(T, DEPTH), a generic sync FIFO with push/pop/full/empty. Instantiate it three times: read source, read response, write source.

Test Plan:
- Reads BE, FE, BE issued on cycles 1-3; body returns data 0xA,0xB,0xC on cycles 5-7; both readies high -> BE valid 0xA cycle 6, FE 0xB cycle 7, BE 0xC cycle 8.
- `be_rd_rsp_ready`=0, issue BE then FE, return both -> BE held valid, FE valid stays 0 until BE ready rises; then FE delivered the next cycle.
- 4 reads issued, none returned (RD_DEPTH=4) -> `r_stall`=1 from cycle after 4th issue; one response popped -> `r_stall`=0 next cycle.
- Writes FE, BE issued; acks on cycles 10,11 -> `fe_wr_ack` pulse cycle 11, `be_wr_ack` pulse cycle 12, each one cycle wide; `w_stall` stays 0.
- `body_rd_rsp_valid` with nothing issued -> `err`=1 next cycle and stays 1; no response valid asserted.
- Reset asserted with 3 reads outstanding -> all valids, stalls, and counts 0 immediately; post-reset issue/return works normally.

Source files
------------

// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types: request/response payloads, requester ids and default
// bank-port queue depths.
package scpad_types_pkg;

    localparam int SCPAD_ID_WIDTH   = 4;
    localparam int SCPAD_ADDR_WIDTH = 12;
    localparam int SCPAD_DATA_WIDTH = 32;
    localparam int SCPAD_TAG_WIDTH  = 4;

    localparam int SCPAD_RD_DEPTH = 4;
    localparam int SCPAD_WR_DEPTH = 4;

    localparam logic SCPAD_SRC_BE = 1'b1;
    localparam logic SCPAD_SRC_FE = 1'b0;

    typedef struct packed {
        logic                        write;
        logic [SCPAD_ADDR_WIDTH-1:0] addr;
        logic [SCPAD_DATA_WIDTH-1:0] wdata;
        logic [SCPAD_TAG_WIDTH-1:0]  tag;
    } scpad_req_t;

    typedef struct packed {
        logic [SCPAD_DATA_WIDTH-1:0] data;
        logic [SCPAD_TAG_WIDTH-1:0]  tag;
    } rd_rsp_t;

    // A buffered read response, tagged with the requester it returns to.
    typedef struct packed {
        logic    src;
        rd_rsp_t rsp;
    } rd_rsp_entry_t;

endpackage

// File: rtl/scpad_sync_fifo.sv
// Generic synchronous FIFO with a registered head. Pop on empty is ignored;
// push on full is accepted only when a pop frees a slot in the same cycle.
module scpad_sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/scpad_tail.sv
// Response side of one scratchpad bank port: routes in-order read data and write
// acks back to FE/BE and returns credit stalls to the request head.
module scpad_tail
    import scpad_types_pkg::*;
#(
    parameter logic [SCPAD_ID_WIDTH-1:0] IDX      = '0,
    parameter int                        RD_DEPTH = SCPAD_RD_DEPTH,
    parameter int                        WR_DEPTH = SCPAD_WR_DEPTH
) (
    input  logic    clk,
    input  logic    n_rst,
    input  logic    rd_issue_valid,
    input  logic    rd_issue_src,
    input  logic    wr_issue_valid,
    input  logic    wr_issue_src,
    input  logic    body_rd_rsp_valid,
    input  rd_rsp_t body_rd_rsp,
    input  logic    body_wr_ack_valid,
    output logic    be_rd_rsp_valid,
    output rd_rsp_t be_rd_rsp,
    input  logic    be_rd_rsp_ready,
    output logic    fe_rd_rsp_valid,
    output rd_rsp_t fe_rd_rsp,
    input  logic    fe_rd_rsp_ready,
    output logic    be_wr_ack,
    output logic    fe_wr_ack,
    output logic    r_stall,
    output logic    w_stall,
    output logic    err
);

    localparam int RCW = $clog2(RD_DEPTH) + 1;
    localparam int WCW = $clog2(WR_DEPTH) + 1;
    localparam logic [RCW-1:0] RD_FULL = RD_DEPTH[RCW-1:0];
    localparam logic [WCW-1:0] WR_FULL = WR_DEPTH[WCW-1:0];

    // The bank id is consumed only by the parent for naming and selection.
    localparam logic [SCPAD_ID_WIDTH-1:0] unused_idx = IDX;

    logic          rd_src_full, rd_src_empty, rd_src_head;
    logic          wr_src_full, wr_src_empty, wr_src_head;
    logic          rsp_full, rsp_empty;
    rd_rsp_entry_t rsp_in, rsp_head;

    logic          rd_push, rd_src_pop, rsp_pop;
    logic          wr_push, wr_src_pop;
    logic [RCW-1:0] rd_cnt;
    logic [WCW-1:0] wr_cnt;

    // Offending issues (while stalled) and orphan completions are dropped here.
    assign rd_push    = rd_issue_valid && !r_stall && !rd_src_full;
    assign rd_src_pop = body_rd_rsp_valid && !rd_src_empty && (!rsp_full || rsp_pop);
    assign wr_push    = wr_issue_valid && !w_stall && !wr_src_full;
    assign wr_src_pop = body_wr_ack_valid && !wr_src_empty;

    assign rsp_in.src = rd_src_head;
    assign rsp_in.rsp = body_rd_rsp;

    scpad_sync_fifo #(.T(logic), .DEPTH(RD_DEPTH)) u_rd_src (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (rd_push),
        .push_data (rd_issue_src),
        .pop       (rd_src_pop),
        .head      (rd_src_head),
        .full      (rd_src_full),
        .empty     (rd_src_empty)
    );

    scpad_sync_fifo #(.T(rd_rsp_entry_t), .DEPTH(RD_DEPTH)) u_rd_rsp (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (rd_src_pop),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .head      (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    scpad_sync_fifo #(.T(logic), .DEPTH(WR_DEPTH)) u_wr_src (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (wr_push),
        .push_data (wr_issue_src),
        .pop       (wr_src_pop),
        .head      (wr_src_head),
        .full      (wr_src_full),
        .empty     (wr_src_empty)
    );

    // Handshake: a read response transfers on a cycle where the requester's
    // valid and ready are both high; until then valid stays high and the payload
    // holds. Only the buffer head is offered, so a stalled head blocks the other
    // requester's queued data.
    assign be_rd_rsp_valid = !rsp_empty && (rsp_head.src == SCPAD_SRC_BE);
    assign fe_rd_rsp_valid = !rsp_empty && (rsp_head.src == SCPAD_SRC_FE);
    assign be_rd_rsp       = be_rd_rsp_valid ? rsp_head.rsp : '0;
    assign fe_rd_rsp       = fe_rd_rsp_valid ? rsp_head.rsp : '0;
    assign rsp_pop         = (be_rd_rsp_valid && be_rd_rsp_ready) ||
                             (fe_rd_rsp_valid && fe_rd_rsp_ready);

    assign r_stall = (rd_cnt == RD_FULL);
    assign w_stall = (wr_cnt == WR_FULL);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_push && !rsp_pop) begin
                rd_cnt <= rd_cnt + RCW'(1);
            end else if (rsp_pop && !rd_push) begin
                rd_cnt <= rd_cnt - RCW'(1);
            end
            if (wr_push && !wr_src_pop) begin
                wr_cnt <= wr_cnt + WCW'(1);
            end else if (wr_src_pop && !wr_push) begin
                wr_cnt <= wr_cnt - WCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            be_wr_ack <= 1'b0;
            fe_wr_ack <= 1'b0;
            err       <= 1'b0;
        end else begin
            be_wr_ack <= wr_src_pop && (wr_src_head == SCPAD_SRC_BE);
            fe_wr_ack <= wr_src_pop && (wr_src_head == SCPAD_SRC_FE);
            err       <= err
                         || (body_rd_rsp_valid && rd_src_empty)
                         || (body_wr_ack_valid && wr_src_empty)
                         || (rd_issue_valid && r_stall)
                         || (wr_issue_valid && w_stall);
        end
    end

endmodule

// File: tb/tb_scpad_tail.sv
// Bench for scpad_tail: hand-derived vector table, directed corner sequences and
// constrained-random traffic checked against a queue-based model.
module tb_scpad_tail;
    import scpad_types_pkg::*;

    localparam int RD_DEPTH = 4;
    localparam int WR_DEPTH = 4;
    localparam int OW = 79;

    logic    clk = 1'b0;
    logic    n_rst;
    logic    rd_issue_valid, rd_issue_src, wr_issue_valid, wr_issue_src;
    logic    body_rd_rsp_valid, body_wr_ack_valid;
    rd_rsp_t body_rd_rsp;
    logic    be_rd_rsp_valid, fe_rd_rsp_valid, be_rd_rsp_ready, fe_rd_rsp_ready;
    rd_rsp_t be_rd_rsp, fe_rd_rsp;
    logic    be_wr_ack, fe_wr_ack, r_stall, w_stall, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scpad_tail #(.IDX('0), .RD_DEPTH(RD_DEPTH), .WR_DEPTH(WR_DEPTH)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .rd_issue_valid    (rd_issue_valid),
        .rd_issue_src      (rd_issue_src),
        .wr_issue_valid    (wr_issue_valid),
        .wr_issue_src      (wr_issue_src),
        .body_rd_rsp_valid (body_rd_rsp_valid),
        .body_rd_rsp       (body_rd_rsp),
        .body_wr_ack_valid (body_wr_ack_valid),
        .be_rd_rsp_valid   (be_rd_rsp_valid),
        .be_rd_rsp         (be_rd_rsp),
        .be_rd_rsp_ready   (be_rd_rsp_ready),
        .fe_rd_rsp_valid   (fe_rd_rsp_valid),
        .fe_rd_rsp         (fe_rd_rsp),
        .fe_rd_rsp_ready   (fe_rd_rsp_ready),
        .be_wr_ack         (be_wr_ack),
        .fe_wr_ack         (fe_wr_ack),
        .r_stall           (r_stall),
        .w_stall           (w_stall),
        .err               (err)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit      src;
        rd_rsp_t rsp;
    } m_ent_t;

    bit     rd_src_q[$];
    m_ent_t rsp_q[$];
    bit     wr_src_q[$];
    bit     m_be_ack, m_fe_ack, m_err;

    function automatic void model_clear();
        rd_src_q.delete();
        rsp_q.delete();
        wr_src_q.delete();
        m_be_ack = 0;
        m_fe_ack = 0;
        m_err    = 0;
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic    bev, fev, rs, ws;
        rd_rsp_t bp, fp;
        bev = 0; fev = 0; bp = '0; fp = '0;
        if (rsp_q.size() > 0) begin
            bev = rsp_q[0].src;
            fev = !rsp_q[0].src;
            if (bev) bp = rsp_q[0].rsp;
            if (fev) fp = rsp_q[0].rsp;
        end
        rs = ((rd_src_q.size() + rsp_q.size()) == RD_DEPTH);
        ws = (wr_src_q.size() == WR_DEPTH);
        return {bev, bp, fev, fp, m_be_ack, m_fe_ack, rs, ws, m_err};
    endfunction

    // Applies this cycle's inputs to the model; call before the rising edge.
    function automatic void model_step();
        bit     rs, ws, deliver, rd_orphan, ack_orphan, s;
        m_ent_t e;
        rs         = ((rd_src_q.size() + rsp_q.size()) == RD_DEPTH);
        ws         = (wr_src_q.size() == WR_DEPTH);
        deliver    = (rsp_q.size() > 0) && (rsp_q[0].src ? be_rd_rsp_ready : fe_rd_rsp_ready);
        rd_orphan  = body_rd_rsp_valid && (rd_src_q.size() == 0);
        ack_orphan = body_wr_ack_valid && (wr_src_q.size() == 0);
        m_be_ack = 0;
        m_fe_ack = 0;
        if (rd_orphan || ack_orphan || (rd_issue_valid && rs) || (wr_issue_valid && ws)) m_err = 1;
        if (deliver) void'(rsp_q.pop_front());
        if (body_rd_rsp_valid && !rd_orphan) begin
            s     = rd_src_q.pop_front();
            e.src = s;
            e.rsp = body_rd_rsp;
            rsp_q.push_back(e);
        end
        if (rd_issue_valid && !rs) rd_src_q.push_back(rd_issue_src);
        if (body_wr_ack_valid && !ack_orphan) begin
            s = wr_src_q.pop_front();
            if (s) m_be_ack = 1;
            else   m_fe_ack = 1;
        end
        if (wr_issue_valid && !ws) wr_src_q.push_back(wr_issue_src);
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [OW-1:0] dut_out();
        return {be_rd_rsp_valid, be_rd_rsp, fe_rd_rsp_valid, fe_rd_rsp,
                be_wr_ack, fe_wr_ack, r_stall, w_stall, err};
    endfunction

    function automatic rd_rsp_t mkrsp(input logic [31:0] d, input logic [3:0] t);
        rd_rsp_t r;
        r.data = d;
        r.tag  = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic rs, input logic wv, input logic ws,
                         input logic bv, input rd_rsp_t br, input logic av);
        rd_issue_valid    = rv;
        rd_issue_src      = rs;
        wr_issue_valid    = wv;
        wr_issue_src      = ws;
        body_rd_rsp_valid = bv;
        body_rd_rsp       = br;
        body_wr_ack_valid = av;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, '0, 0);
    endtask

    // Called at the falling edge: compare against the model, advance it, then
    // move to just after the rising edge where the next inputs are driven.
    task automatic cycle_end(input string name);
        chk(name, dut_out(), model_out());
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input string name);
        @(negedge clk);
        cycle_end(name);
    endtask

    task automatic reset_dut();
        idle();
        n_rst = 1'b0;
        #1;
        chk("reset_async", dut_out(), '0);
        model_clear();
        tick("in_reset");
        tick("in_reset");
        n_rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rdv, rds, wrv, wrs, bv;
        logic [31:0] bd;
        logic        av;
        logic        ebv, efv;
        logic [31:0] ed;
        logic        eba, efa, ers, ews, eer;
    } vec_t;

    function automatic vec_t mk(input logic rdv, input logic rds, input logic wrv, input logic wrs,
                                input logic bv, input logic [31:0] bd, input logic av,
                                input logic ebv, input logic efv, input logic [31:0] ed,
                                input logic eba, input logic efa, input logic ers,
                                input logic ews, input logic eer);
        vec_t v;
        v.rdv = rdv; v.rds = rds; v.wrv = wrv; v.wrs = wrs; v.bv = bv; v.bd = bd; v.av = av;
        v.ebv = ebv; v.efv = efv; v.ed = ed; v.eba = eba; v.efa = efa;
        v.ers = ers; v.ews = ews; v.eer = eer;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        rd_rsp_t act_pay, exp_pay;

        tbl[0]  = mk(1, 1, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 32'hA, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'hB, 0,  1, 0, 32'hA, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 32'hC, 0,  0, 1, 32'hB, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 32'h0, 0,  1, 0, 32'hC, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 1, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h0, 1,  0, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0, 1,  0, 0, 32'h0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 32'h0, 0,  0, 0, 32'h0, 0, 0, 0, 0, 0);

        // clock/reset
        n_rst = 1'b0;
        idle();
        be_rd_rsp_ready = 1'b1;
        fe_rd_rsp_ready = 1'b1;
        model_clear();
        #2;
        chk("reset_outputs", dut_out(), '0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // in-order routing and registered write acks
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rdv, tbl[i].rds, tbl[i].wrv, tbl[i].wrs,
                  tbl[i].bv, mkrsp(tbl[i].bd, 4'h3), tbl[i].av);
            @(negedge clk);
            act_pay = be_rd_rsp_valid ? be_rd_rsp : (fe_rd_rsp_valid ? fe_rd_rsp : rd_rsp_t'(0));
            exp_pay = (tbl[i].ebv || tbl[i].efv) ? mkrsp(tbl[i].ed, 4'h3) : rd_rsp_t'(0);
            chk($sformatf("vec%0d", i),
                {be_rd_rsp_valid, fe_rd_rsp_valid, act_pay, be_wr_ack, fe_wr_ack, r_stall, w_stall, err},
                {tbl[i].ebv, tbl[i].efv, exp_pay, tbl[i].eba, tbl[i].efa, tbl[i].ers, tbl[i].ews, tbl[i].eer});
            cycle_end("vec_model");
        end

        // stalled BE head blocks a queued FE response
        be_rd_rsp_ready = 1'b0;
        drive(1, 1, 0, 0, 0, '0, 0);                    tick("bp_iss_be");
        drive(1, 0, 0, 0, 0, '0, 0);                    tick("bp_iss_fe");
        drive(0, 0, 0, 0, 1, mkrsp(32'h11, 4'h1), 0);   tick("bp_rsp1");
        drive(0, 0, 0, 0, 1, mkrsp(32'h22, 4'h2), 0);   tick("bp_rsp2");
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_be_held", {be_rd_rsp_valid, be_rd_rsp.data, fe_rd_rsp_valid}, {1'b1, 32'h11, 1'b0});
            cycle_end("bp_hold");
        end
        be_rd_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_be_release", {be_rd_rsp_valid, fe_rd_rsp_valid}, 2'b10);
        cycle_end("bp_release");
        @(negedge clk);
        chk("bp_fe_next", {fe_rd_rsp_valid, fe_rd_rsp.data, be_rd_rsp_valid}, {1'b1, 32'h22, 1'b0});
        cycle_end("bp_fe");
        tick("bp_drain");

        // read credits exhaust and return
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0, 0, '0, 0);
            tick("rs_issue");
        end
        idle();
        @(negedge clk);
        chk("rstall_set", r_stall, 1'b1);
        cycle_end("rs_full");
        drive(0, 0, 0, 0, 1, mkrsp(32'h33, 4'h3), 0);
        @(negedge clk);
        chk("rstall_body", r_stall, 1'b1);
        cycle_end("rs_body");
        idle();
        @(negedge clk);
        chk("rstall_pop_cycle", {be_rd_rsp_valid, r_stall}, 2'b11);
        cycle_end("rs_pop");
        @(negedge clk);
        chk("rstall_clear", r_stall, 1'b0);
        cycle_end("rs_clear");
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, mkrsp(32'h40 + k, 4'h4), 0);
            tick("rs_drain");
        end
        idle();
        tick("rs_idle");
        tick("rs_idle");

        // write credits exhaust, then an over-issue flags err
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 0, 0, '0, 0);
            tick("ws_issue");
        end
        idle();
        @(negedge clk);
        chk("wstall_set", w_stall, 1'b1);
        cycle_end("ws_full");
        drive(0, 0, 1, 1, 0, '0, 0);
        tick("ws_over");
        idle();
        @(negedge clk);
        chk("wover_err", {err, w_stall}, 2'b11);
        cycle_end("ws_err");
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, '0, 1);
            tick("ws_ack");
        end
        idle();
        tick("ws_idle");
        reset_dut();

        // orphan read response
        drive(0, 0, 0, 0, 1, mkrsp(32'h44, 4'h4), 0);
        tick("orphan");
        idle();
        @(negedge clk);
        chk("orphan_err", {err, be_rd_rsp_valid, fe_rd_rsp_valid}, 3'b100);
        cycle_end("orphan_chk");
        tick("orphan_sticky");
        tick("orphan_sticky");

        // reset with reads, buffered data and an ack pulse in flight
        be_rd_rsp_ready = 1'b0;
        drive(0, 0, 1, 1, 0, '0, 0);                    tick("mr_wr");
        drive(1, 1, 0, 0, 0, '0, 0);                    tick("mr_rd");
        drive(1, 1, 0, 0, 0, '0, 0);                    tick("mr_rd");
        drive(1, 1, 0, 0, 0, '0, 0);                    tick("mr_rd");
        drive(0, 0, 0, 0, 1, mkrsp(32'h55, 4'h5), 0);   tick("mr_rsp");
        drive(0, 0, 0, 0, 1, mkrsp(32'h66, 4'h6), 1);   tick("mr_rsp_ack");
        chk("pre_reset", {be_wr_ack, be_rd_rsp_valid, err}, 3'b111);
        reset_dut();
        be_rd_rsp_ready = 1'b1;
        drive(1, 0, 0, 0, 0, '0, 0);                    tick("pr_rd");
        drive(0, 0, 0, 0, 1, mkrsp(32'h77, 4'h7), 0);   tick("pr_rsp");
        idle();
        @(negedge clk);
        chk("post_reset_fe", {fe_rd_rsp_valid, fe_rd_rsp.data, err}, {1'b1, 32'h77, 1'b0});
        cycle_end("pr_fe");
        tick("pr_idle");

        // constrained-random traffic that honours credits
        for (int c = 0; c < 400; c++) begin
            logic rv, wv, bv, av;
            rv = ((rd_src_q.size() + rsp_q.size()) < RD_DEPTH) && ($urandom_range(0, 2) != 0);
            wv = (wr_src_q.size() < WR_DEPTH) && ($urandom_range(0, 2) != 0);
            bv = (rd_src_q.size() > 0) && ($urandom_range(0, 1) != 0);
            av = (wr_src_q.size() > 0) && ($urandom_range(0, 1) != 0);
            drive(rv, 1'($urandom_range(0, 1)), wv, 1'($urandom_range(0, 1)),
                  bv, mkrsp($urandom, 4'($urandom_range(0, 15))), av);
            be_rd_rsp_ready = ($urandom_range(0, 3) != 0);
            fe_rd_rsp_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end
        idle();
        be_rd_rsp_ready = 1'b1;
        fe_rd_rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
